// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and defaults for the transmit arbiter.
// Imported by tx_arbiter.
package tx_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} tx_arb_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans req upward from ptr, wrapping; returns one-hot grant and index.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    // first set request at or above ptr, wrapping modulo N
    always_comb begin
        logic found;
        int   j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one serial transmitter.
// Optional WAIT timeout with err_o when TX_ARB_TIMEOUT_EN is defined.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    tx_en_o,
    output logic                    tx_load_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_char_sent_i
`ifdef TX_ARB_TIMEOUT_EN
    ,
    output logic                    err_o
`endif
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
        $error("tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_t
        $error("tx_arbiter: TIMEOUT_CYC must be >= 1");
    end

    tx_arb_state_t     state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gidx;
    logic              sent_q;
    logic              sent_edge;
    logic [N_REQ-1:0]  pick_grant;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     ptr_next;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    logic          expired;
    assign expired = (cnt == CW'(TIMEOUT_CYC - 1));
`endif

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign sent_edge = tx_char_sent_i & ~sent_q;
    assign busy_o    = (state != IDLE);
    assign ptr_next  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // char_sent history for rising-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) sent_q <= 1'b0;
        else       sent_q <= tx_char_sent_i;
    end

    // arbitration FSM with registered transmitter controls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant_o   <= '0;
            ack_o     <= '0;
            tx_en_o   <= 1'b0;
            tx_load_o <= 1'b0;
            tx_data_o <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_o     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    ack_o <= '0;
                    if (|req_i) begin
                        grant_o   <= pick_grant;
                        gidx      <= pick_idx;
                        tx_data_o <= data_i[int'(pick_idx)*DATA_W +: DATA_W];
                        tx_load_o <= 1'b1;
                        tx_en_o   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    tx_load_o <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                    state     <= WAIT;
                end
                WAIT: begin
`ifdef TX_ARB_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (sent_edge || expired) begin
                        err_o   <= ~sent_edge;
                        ack_o   <= grant_o;
                        grant_o <= '0;
                        tx_en_o <= 1'b0;
                        state   <= DONE;
                    end
`else
                    if (sent_edge) begin
                        ack_o   <= grant_o;
                        grant_o <= '0;
                        tx_en_o <= 1'b0;
                        state   <= DONE;
                    end
`endif
                end
                DONE: begin
                    ack_o <= '0;
                    ptr   <= ptr_next;
`ifdef TX_ARB_TIMEOUT_EN
                    err_o <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed vectors plus hand sequences for tx_arbiter.
// Covers the TX_ARB_TIMEOUT_EN path when that macro is defined.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        en;
    logic        load;
    logic [7:0]  txd;
    logic        sent;
`ifdef TX_ARB_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    tx_arbiter #(
        .N_REQ       (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .data_i         (data),
        .ack_o          (ack),
        .grant_o        (grant),
        .busy_o         (busy),
        .tx_en_o        (en),
        .tx_load_o      (load),
        .tx_data_o      (txd),
        .tx_char_sent_i (sent)
`ifdef TX_ARB_TIMEOUT_EN
        ,
        .err_o          (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] data;
        logic        sent;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic        busy;
        logic        en;
        logic        load;
        logic [7:0]  txd;
    } vec_t;

    vec_t tv[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // wait (bounded) until the LOAD cycle is visible
    task automatic wait_load(input string name);
        int n;
        n = 0;
        step();
        while (!load && n < 12) begin
            step();
            n++;
        end
        chk({name, " load_seen"}, {31'd0, load}, 32'd1);
    endtask

    task automatic serve(input int idx, input logic [7:0] b);
        wait_load("rr");
        chk("rr grant", {28'd0, grant}, 32'd1 << idx);
        chk("rr txd", {24'd0, txd}, {24'd0, b});
        step();
        step();
        sent = 1'b1;
        step();
        chk("rr ack", {28'd0, ack}, 32'd1 << idx);
        sent = 1'b0;
        step();
        chk("rr ack_clear", {28'd0, ack}, 32'd0);
        chk("rr idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // req  data  sent | grant ack busy en load txd
        tv[0]  = {4'h1, 32'h0000_00B2, 1'b0, 4'h1, 4'h0, 3'b111, 8'hB2};
        tv[1]  = {4'h1, 32'h0000_00B2, 1'b0, 4'h1, 4'h0, 3'b110, 8'hB2};
        tv[2]  = {4'h1, 32'h0000_00B2, 1'b0, 4'h1, 4'h0, 3'b110, 8'hB2};
        tv[3]  = {4'h1, 32'h0000_00B2, 1'b0, 4'h1, 4'h0, 3'b110, 8'hB2};
        tv[4]  = {4'h1, 32'h0000_00B2, 1'b0, 4'h1, 4'h0, 3'b110, 8'hB2};
        tv[5]  = {4'h1, 32'h0000_00B2, 1'b1, 4'h0, 4'h1, 3'b100, 8'hB2};
        tv[6]  = {4'h0, 32'h0000_00B2, 1'b1, 4'h0, 4'h0, 3'b000, 8'hB2};
        tv[7]  = {4'h0, 32'h0000_00B2, 1'b0, 4'h0, 4'h0, 3'b000, 8'hB2};
        tv[8]  = {4'h0, 32'h0000_00C3, 1'b1, 4'h0, 4'h0, 3'b000, 8'hB2};
        tv[9]  = {4'h1, 32'h0000_00C3, 1'b0, 4'h1, 4'h0, 3'b111, 8'hC3};
        tv[10] = {4'h1, 32'h0000_00C3, 1'b1, 4'h1, 4'h0, 3'b110, 8'hC3};
        tv[11] = {4'h1, 32'h0000_00C3, 1'b1, 4'h1, 4'h0, 3'b110, 8'hC3};
        tv[12] = {4'h1, 32'h0000_00C3, 1'b0, 4'h1, 4'h0, 3'b110, 8'hC3};
        tv[13] = {4'h1, 32'h0000_00C3, 1'b1, 4'h0, 4'h1, 3'b110 & 3'b100, 8'hC3};
        tv[14] = {4'h0, 32'h0000_00C3, 1'b0, 4'h0, 4'h0, 3'b000, 8'hC3};

        rst  = 1'b1;
        req  = '0;
        data = '0;
        sent = 1'b0;
        step();
        step();
        chk("rst grant", {28'd0, grant}, 32'd0);
        chk("rst ack", {28'd0, ack}, 32'd0);
        chk("rst ctl", {29'd0, busy, en, load}, 32'd0);
        chk("rst txd", {24'd0, txd}, 32'd0);
        rst = 1'b0;

        // single requester, then sent pulses in IDLE and LOAD
        for (int i = 0; i < 15; i++) begin
            req  = tv[i].req;
            data = tv[i].data;
            sent = tv[i].sent;
            step();
            chk($sformatf("v%0d grant", i), {28'd0, grant}, {28'd0, tv[i].grant});
            chk($sformatf("v%0d ack", i), {28'd0, ack}, {28'd0, tv[i].ack});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, tv[i].busy});
            chk($sformatf("v%0d en", i), {31'd0, en}, {31'd0, tv[i].en});
            chk($sformatf("v%0d load", i), {31'd0, load}, {31'd0, tv[i].load});
            chk($sformatf("v%0d txd", i), {24'd0, txd}, {24'd0, tv[i].txd});
        end

        // round robin from ptr 0 with all requesters held
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req  = 4'b1111;
        data = 32'h4433_2211;
        serve(0, 8'h11);
        serve(1, 8'h22);
        serve(2, 8'h33);
        serve(3, 8'h44);
        serve(0, 8'h11);
        req = '0;
        step();

        // latched byte survives data change and req drop
        req  = 4'b0100;
        data = 32'h005A_0000;
        wait_load("hold");
        chk("hold grant", {28'd0, grant}, 32'd4);
        step();
        data = 32'h00FF_0000;
        req  = '0;
        step();
        step();
        chk("hold txd", {24'd0, txd}, 32'h5A);
        sent = 1'b1;
        step();
        chk("hold ack", {28'd0, ack}, 32'd4);
        chk("hold txd_done", {24'd0, txd}, 32'h5A);
        sent = 1'b0;
        step();

        // reset during WAIT, then ptr back at 0
        req  = 4'b0001;
        data = 32'h0000_0077;
        wait_load("rst");
        step();
        chk("rstw busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req = '0;
        step();
        chk("rstw grant", {28'd0, grant}, 32'd0);
        chk("rstw ack", {28'd0, ack}, 32'd0);
        chk("rstw ctl", {29'd0, busy, en, load}, 32'd0);
        chk("rstw txd", {24'd0, txd}, 32'd0);
        rst = 1'b0;
        req = 4'b1010;
        step();
        chk("rstw regrant", {28'd0, grant}, 32'd2);
        step();
        sent = 1'b1;
        step();
        chk("rstw ack2", {28'd0, ack}, 32'd2);
        sent = 1'b0;
        req  = '0;
        step();

`ifdef TX_ARB_TIMEOUT_EN
        // no char_sent: timeout after 8 WAIT cycles
        req  = 4'b0001;
        data = 32'h0000_0099;
        wait_load("to");
        req = '0;
        step();
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("to quiet%0d", k), {28'd0, ack, err}, 32'd0);
        end
        step();
        chk("to err", {31'd0, err}, 32'd1);
        chk("to ack", {28'd0, ack}, 32'd1);
        step();
        chk("to err_clear", {31'd0, err}, 32'd0);
        chk("to idle", {31'd0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares one serial transmit datapath between N_REQ byte-level requesters, using round-robin arbitration.
- Per character:
  - latches the winning requester's byte;
  - pulses the transmitter's load and enable controls;
  - waits for the transmitter's char-sent indication;
  - returns a one-cycle ack to the winner.
- Sits between the game-logic message sources and the transmit block, in the baud (clk_i) domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, character width; must match the transmitter's parallel data width.
- TIMEOUT_CYC, 64, clk_i cycles allowed in WAIT before abort. Used only with TX_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  baud-domain clock; same clock as the transmitter's clk_i.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  level request per requester; held until ack_o.
- data_i  in  N_REQ*DATA_W  requester r's byte is data_i[r*DATA_W +: DATA_W].
- ack_o  out  N_REQ  one-cycle pulse to the requester whose character finished.
- grant_o  out  N_REQ  one-hot current owner; all zeros when idle.
- busy_o  out  1  high in any state except IDLE.
- tx_en_o  out  1  drives the transmitter's trans_en_i.
- tx_load_o  out  1  drives the transmitter's load_i.
- tx_data_o  out  DATA_W  drives the transmitter's para_data_i.
- tx_char_sent_i  in  1  from the transmitter's char_sent_o.
- err_o  out  1  timeout pulse. Present only with TX_ARB_TIMEOUT_EN.

Behaviour:
Reset:
- All outputs are 0; state is IDLE; priority pointer is 0 (requester 0 highest).
- The sent-edge register is cleared.
- Reset mid-transfer aborts immediately. No ack is issued; the latched byte is discarded.

Sent detection:
- sent_edge = tx_char_sent_i & ~tx_char_sent_q, where tx_char_sent_q is tx_char_sent_i registered each cycle.
- Only rising edges count, so a level or pulse char_sent both work.

FSM (registered outputs):
- IDLE:
  - If req_i != 0, select the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Latch data into tx_data_o and set grant_o one-hot. Next state is LOAD.
  - Grant latency: 1 cycle from req_i high to grant_o.
- LOAD (1 cycle):
  - tx_load_o = 1 and tx_en_o = 1.
  - Next state is WAIT.
- WAIT:
  - tx_en_o = 1, tx_load_o = 0, tx_data_o held stable.
  - On sent_edge, next state is DONE.
- DONE (1 cycle):
  - ack_o[g] = 1, grant_o cleared, tx_en_o = 0.
  - ptr <= (g+1) mod N_REQ.
  - Next state is IDLE.

Boundary conditions:
- Requests that arrive simultaneously are resolved by ptr. There is no starvation: the just-served requester becomes lowest priority.
- req_i dropping mid-transfer does not abort. The character completes and ack_o still pulses.
- data_i changes after grant are ignored, because the byte was latched in IDLE.
- A sent_edge seen in IDLE, LOAD or DONE is ignored; only WAIT consumes it.
- Back-to-back service: a requester still asserting req_i in the cycle after ack is treated as a new request. Minimum gap between characters is 1 IDLE cycle.
- A single requester holding req_i continuously gets one character per IDLE→DONE loop.
- req_i bits at or above N_REQ do not exist. ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without sent_edge, go to DONE with err_o = 1 for that cycle. ack_o still pulses so the requester is released.
  - ptr advances normally.
- Undefined:
  - No counter and no err_o port; WAIT waits indefinitely.

Decomposition:
- Package tx_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} tx_arb_state_t;
  - localparam DEFAULT_DATA_W = 8.
- Sub-module rr_pick (combinational):
  - Inputs req and ptr; outputs a one-hot grant and its index.
  - Reusable by other shared resources.

Test Plan:
- Reset, then req_i=4'b0001, data_i[7:0]=8'hB2:
  - grant_o=0001 one cycle later, then tx_load_o pulse with tx_data_o=B2.
  - Drive char_sent high 5 cycles later: ack_o=0001 exactly one cycle, busy_o drops.
- req_i=4'b1111 held, bytes 11/22/33/44 with each char_sent answered:
  - Service order is 0,1,2,3,0. Acks never overlap; tx_data_o follows the order.
- Grant requester 2, change data_i for requester 2 and drop req_i during WAIT:
  - tx_data_o keeps the original byte; ack_o[2] still pulses.
- Pulse char_sent during IDLE and during LOAD:
  - No ack. Only the pulse in WAIT completes the transfer.
- Assert rst_i during WAIT:
  - Next cycle all outputs are 0, no ack, ptr=0.
  - A subsequent req_i=4'b1010 grants requester 1 first.
- With TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, never assert char_sent:
  - err_o and ack_o pulse together 8 cycles after WAIT entry; return to IDLE.
